// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative multiply/divide unit.
//   md_op_e    - operation encodings (op[1] selects divide, op[0] selects signed)
//   md_state_e - sequencer states
//   cnt_width  - iteration counter width for a given operand width
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10
    } md_state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the control unit and muldiv_unit.
//   master drives start/op/a/b and observes busy/done/hi/lo/div_by_zero;
//   slave (the unit) is the opposite side.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negation.
//   en - negate when high, pass through otherwise
//   x  - input value (W bits)
//   y  - result (W bits, combinational)
module muldiv_negate #(
    parameter int unsigned W = 32
) (
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS mult/multu/div/divu producing HI/LO.
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   bus (slave)  - start/op/a/b request, busy/done/hi/lo/div_by_zero result
// Fixed latency of WIDTH+1 edges from the start edge to done.
// Build option MULDIV_DIV_EN: when defined the divide datapath is built;
// otherwise divide ops run the full latency and complete with zero results.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);

    md_state_e       state_q, state_d;
    md_op_e          op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [W2-1:0]   acc_q, acc_d;       // product, or quotient in the low half
    logic            neg_q, neg_d;       // result sign (operand signs differ)
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            dbz_q, dbz_d;

    // Operand magnitudes at load; op[0] marks a signed operation
    logic            a_neg_en, b_neg_en;
    logic [W-1:0]    a_mag, b_mag;

    assign a_neg_en = bus.op[0] & bus.a[W-1];
    assign b_neg_en = bus.op[0] & bus.b[W-1];

    muldiv_negate #(.W(W)) u_neg_a (.en(a_neg_en), .x(bus.a), .y(a_mag));
    muldiv_negate #(.W(W)) u_neg_b (.en(b_neg_en), .x(bus.b), .y(b_mag));

    // Shift-add step: add multiplicand to the upper half when the LSB is set
    logic [W:0]      mul_sum;
    logic [W2-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : (W+1)'(0));
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    logic [W2-1:0]   prod_fix;

    muldiv_negate #(.W(W2)) u_neg_p (
        .en ((op_q == MD_MULT) & neg_q),
        .x  (acc_q),
        .y  (prod_fix)
    );

`ifdef MULDIV_DIV_EN
    logic [W:0]      rem_q, rem_d;       // partial remainder, carry kept
    logic [W-1:0]    a_raw_q, a_raw_d;   // dividend as presented, for divide-by-zero
    logic            rneg_q, rneg_d;     // remainder follows dividend sign
    logic            zdiv_q, zdiv_d;

    // Restoring step: trial subtract on the shifted remainder, keep if non-negative
    logic [W+1:0]    div_shift, div_trial;
    logic            div_ok;

    assign div_shift = {rem_q, acc_q[W-1]};
    assign div_trial = div_shift - {2'b00, mcand_q};
    assign div_ok    = ~div_trial[W+1];

    logic [W-1:0]    quo_fix, rem_fix;

    muldiv_negate #(.W(W)) u_neg_q (
        .en ((op_q == MD_DIV) & neg_q),
        .x  (acc_q[W-1:0]),
        .y  (quo_fix)
    );
    muldiv_negate #(.W(W)) u_neg_r (
        .en (rneg_q),
        .x  (rem_q[W-1:0]),
        .y  (rem_fix)
    );
`endif

    // Sequencer and datapath next-state
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
`ifdef MULDIV_DIV_EN
        rem_d   = rem_q;
        a_raw_d = a_raw_q;
        rneg_d  = rneg_q;
        zdiv_d  = zdiv_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    op_d    = md_op_e'(bus.op);
                    cnt_d   = CW'(W - 1);
                    neg_d   = a_neg_en ^ b_neg_en;
                    busy_d  = 1'b1;
                    if (bus.op[1]) begin
                        mcand_d = b_mag;
                        acc_d   = {W'(0), a_mag};
                    end else begin
                        mcand_d = a_mag;
                        acc_d   = {W'(0), b_mag};
                    end
`ifdef MULDIV_DIV_EN
                    rem_d   = (W+1)'(0);
                    a_raw_d = bus.a;
                    rneg_d  = bus.op[1] & a_neg_en;
                    zdiv_d  = bus.op[1] & (bus.b == W'(0));
`endif
                end
            end

            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(0)) begin
                    state_d = SIGN;
                end
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    rem_d = div_ok ? div_trial[W:0] : div_shift[W:0];
                    acc_d = {acc_q[W2-1:W], acc_q[W-2:0], div_ok};
                end else begin
                    acc_d = mul_next;
                end
`else
                acc_d = mul_next;
`endif
            end

            SIGN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    if (zdiv_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    dbz_d = zdiv_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                    dbz_d        = 1'b0;
                end
`else
                if (op_q[1]) begin
                    hi_d = W'(0);
                    lo_d = W'(0);
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                dbz_d = 1'b0;
`endif
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= MD_MULTU;
            cnt_q   <= CW'(0);
            mcand_q <= W'(0);
            acc_q   <= W2'(0);
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= W'(0);
            lo_q    <= W'(0);
            dbz_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_q   <= (W+1)'(0);
            a_raw_q <= W'(0);
            rneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
`ifdef MULDIV_DIV_EN
            rem_q   <= rem_d;
            a_raw_q <= a_raw_d;
            rneg_q  <= rneg_d;
            zdiv_q  <= zdiv_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule
